// File: rtl/alu_share_arbiter.sv
// Two-requester front end for a single shared ALU instance.
// Requesters compete through a one-bit round-robin arbiter. The winning
// operation is latched into operand registers and driven to the ALU. Its
// result is captured one cycle later and held as a response until the
// consumer takes it.
module alu_share_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_ctrl,
  output logic [DATA_W-1:0] alu_srca,
  output logic [DATA_W-1:0] alu_srcb,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic              last_grant;
  logic [DATA_W-1:0] op_a_p0;
  logic [DATA_W-1:0] op_b_p0;
  logic [3:0]        op_ctrl_p0;
  logic              op_id_p0;
  logic              pick0;
  logic              pick1;
  logic              open;

  // Round-robin pick: on a tie the requester that did not win last time is served
  always_comb begin
    pick0      = req0_valid & (~req1_valid | last_grant);
    pick1      = req1_valid & (~req0_valid | ~last_grant);
    open       = (state == IDLE) & ~flush & ~rst;
    req0_ready = open & pick0;
    req1_ready = open & pick1;
  end

  // The ALU always sees the operand registers, so its inputs only move on a grant
  assign alu_srca = op_a_p0;
  assign alu_srcb = op_b_p0;
  assign alu_ctrl = op_ctrl_p0;

  // FSM: operand latch on grant, result capture after EXEC, response hold until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_a_p0    <= '0;
      op_b_p0    <= '0;
      op_ctrl_p0 <= 4'b0000;
      op_id_p0   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            op_a_p0    <= req0_a;
            op_b_p0    <= req0_b;
            op_ctrl_p0 <= req0_ctrl;
            op_id_p0   <= 1'b0;
            last_grant <= 1'b0;
            state      <= EXEC;
          end else if (req1_ready) begin
            op_a_p0    <= req1_a;
            op_b_p0    <= req1_b;
            op_ctrl_p0 <= req1_ctrl;
            op_id_p0   <= 1'b1;
            last_grant <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_id     <= op_id_p0;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
